// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared by the timing source and every draw stage.
// Pure wiring: no latency of its own.
// No backpressure: timing is free-running and consumers follow it.
interface vga_tim;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk
  );

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running h/v counters with registered sync/blank flags.
// Latency: every output is a register; flags and counters describe the same pixel.
// Backpressure: none; en=0 freezes every output and suppresses frame_start.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_ACT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_tim.out         tim_out,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 11 bits; a raster that does not fit must not elaborate.
  generate
    if (H_TOTAL > 2048) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL exceeds 11-bit counter range");
    end
    if (V_TOTAL > 2048) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL exceeds 11-bit counter range");
    end
  endgenerate

  // Last count of each axis, where the counter wraps.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Decode boundaries, one bit wider so an active width of 2048 still compares correctly.
  localparam logic [11:0] H_BLNK_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_BLNK_BEG = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q,  hsync_d;
  logic        vsync_q,  vsync_d;
  logic        hblnk_q,  hblnk_d;
  logic        vblnk_q,  vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap;
  logic [11:0] h_nxt_x;
  logic [11:0] v_nxt_x;

  assign h_wrap  = (hcount_q == H_LAST);
  assign h_nxt_x = {1'b0, hcount_d};
  assign v_nxt_x = {1'b0, vcount_d};

  // Counter advance: h steps every enabled cycle, v steps only when h wraps.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (h_wrap) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + 11'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // Flag decode from the next counter values so flags line up with the counters they describe.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    frame_start_d = 1'b0;
    if (en) begin
      hblnk_d = (h_nxt_x >= H_BLNK_BEG);
      vblnk_d = (v_nxt_x >= V_BLNK_BEG);
      hsync_d = ((h_nxt_x >= H_SYNC_BEG) && (h_nxt_x < H_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d = ((v_nxt_x >= V_SYNC_BEG) && (v_nxt_x < V_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
      // Only an actual advance onto (0,0) marks a frame start; reset alone never does.
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  // State registers; reset parks on pixel (0,0) with syncs deasserted and no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim_out.hcount = hcount_q;
  assign tim_out.vcount = vcount_q;
  assign tim_out.hsync  = hsync_q;
  assign tim_out.vsync  = vsync_q;
  assign tim_out.hblnk  = hblnk_q;
  assign tim_out.vblnk  = vblnk_q;
  assign frame_start    = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count moves on the same edge that raises frame_start, so the pulse cycle shows the new count.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
  end

  // Frame counter register; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } obs_t;

  // Small raster with active-low syncs: 25 x 14, frame = 350 cycles.
  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 3;
  localparam logic S_SA = 1'b0;
  localparam int S_FRAME = 350;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic fs_s, fs_b;

  vga_tim tim_s();
  vga_tim tim_b();

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_s, fc_b;
  logic [15:0] fcm_s = 16'd0;
  logic [15:0] fcm_b = 16'd0;
`endif

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_ACT(S_SA)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .tim_out(tim_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  vga_timing_gen u_big (
    .clk(clk), .rst(rst), .en(en), .tim_out(tim_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_fs     = -1;
  obs_t ms, mb;
  obs_t qs[$];
  obs_t qb[$];

  function automatic obs_t rst_state(input logic sa);
    obs_t r;
    r    = '0;
    r.hs = ~sa;
    r.vs = ~sa;
    return r;
  endfunction

  function automatic obs_t step(input obs_t c, input logic e,
                                input int ha, input int hf, input int hsw, input int hbp,
                                input int va, input int vf, input int vsw, input int vbp,
                                input logic sa);
    obs_t n;
    int h, v, ht, vt;
    n    = c;
    n.fs = 1'b0;
    if (!e) return n;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    h  = int'(c.h) + 1;
    v  = int'(c.v);
    if (h == ht) begin
      h = 0;
      v = v + 1;
      if (v == vt) v = 0;
    end
    n.h  = 11'(h);
    n.v  = 11'(v);
    n.hb = (h >= ha);
    n.vb = (v >= va);
    n.hs = (h >= ha + hf && h < ha + hf + hsw) ? sa : ~sa;
    n.vs = (v >= va + vf && v < va + vf + vsw) ? sa : ~sa;
    n.fs = (h == 0) && (v == 0);
    return n;
  endfunction

  function automatic obs_t samp_s();
    return {tim_s.hcount, tim_s.vcount, tim_s.hsync, tim_s.vsync, tim_s.hblnk, tim_s.vblnk, fs_s};
  endfunction

  function automatic obs_t samp_b();
    return {tim_b.hcount, tim_b.vcount, tim_b.hsync, tim_b.vsync, tim_b.hblnk, tim_b.vblnk, fs_b};
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
             tag, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
             exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive en, predict both DUTs into the scoreboard, then compare after the edge.
  task automatic tick(input logic e);
    en = e;
    if (rst) begin
      ms = rst_state(S_SA);
      mb = rst_state(1'b1);
    end else begin
      ms = step(ms, e, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_SA);
      mb = step(mb, e, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1);
    end
    qs.push_back(ms);
    qb.push_back(mb);
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (rst) begin
      fcm_s = 16'd0;
      fcm_b = 16'd0;
    end else begin
      if (ms.fs) fcm_s = fcm_s + 16'd1;
      if (mb.fs) fcm_b = fcm_b + 16'd1;
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
    check("small", samp_s(), qs.pop_front());
    check("big", samp_b(), qb.pop_front());
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_int("frame_cnt_small", int'(fc_s), int'(fcm_s));
    check_int("frame_cnt_big", int'(fc_b), int'(fcm_b));
`endif
    if (fs_s) begin
      if (last_fs >= 0) check_int("fs_spacing", cyc - last_fs, S_FRAME);
      last_fs = cyc;
    end
  endtask

  initial begin
    int hs_cnt;
    int hb_cnt;
    int n;
    logic hit;

    ms = rst_state(S_SA);
    mb = rst_state(1'b1);

    // Reset state held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_small", samp_s(), rst_state(S_SA));
    check("reset_big", samp_b(), rst_state(1'b1));
    rst = 1'b0;

    // One full default line: hsync and hblnk widths, then wrap into line 1.
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 0; i < 1344; i++) begin
      tick(1'b1);
      if (tim_b.hsync === 1'b1) hs_cnt++;
      if (tim_b.hblnk === 1'b1) hb_cnt++;
    end
    check_int("line_hsync_width", hs_cnt, 136);
    check_int("line_hblnk_width", hb_cnt, 320);
    check_int("line_wrap_h", int'(tim_b.hcount), 0);
    check_int("line_wrap_v", int'(tim_b.vcount), 1);

    // Freeze mid-frame on the small raster.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick(1'b1);
      hit = (tim_s.hcount == 11'd10) && (tim_s.vcount == 11'd5);
    end
    check_int("reach_freeze_point", int'(hit), 1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check_int("frozen_h", int'(tim_s.hcount), 10);
    end
    tick(1'b1);
    check_int("resume_h", int'(tim_s.hcount), 11);

    // Asynchronous reset between edges, mid-frame.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick(1'b1);
      hit = (tim_s.hcount == 11'd12) && (tim_s.vcount == 11'd7);
    end
    check_int("reach_reset_point", int'(hit), 1);
    #2;
    rst = 1'b1;
    #1;
    ms = rst_state(S_SA);
    mb = rst_state(1'b1);
    qs.push_back(ms);
    qb.push_back(mb);
    check("async_rst_small", samp_s(), qs.pop_front());
    check("async_rst_big", samp_b(), qb.pop_front());
    last_fs = -1;
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;

    // First frame_start after release comes exactly one frame later.
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick(1'b1);
      n++;
      hit = (fs_s === 1'b1);
    end
    check_int("first_fs_after_rst", n, S_FRAME);

    // Two more small frames exercise the spacing check and vsync/vblnk ranges.
    for (int i = 0; i < 2 * S_FRAME; i++) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing stream that draw stages (background, screens, win/lose overlays) consume through the vga_tim interface.
- It is the source end of that interface: free-running horizontal and vertical counters, with sync and blanking flags derived from them.
- Sits at the head of the draw pipeline, clocked by the pixel clock.
- Default timing: 1024x768 @ 60 Hz (65 MHz pixel clock).

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_ACT, 1'b1, asserted level of hsync and vsync

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  advance enable; when low, every output holds its value
- tim_out  vga_tim.out  11/11/1/1/1/1  fields: hcount, vcount, hsync, vsync, hblnk, vblnk
- frame_start  out  1  one-cycle pulse while hcount==0 and vcount==0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Width rules:
  - Counters are 11 bits, unsigned.
  - Elaboration fails (static assertion) if H_TOTAL > 2048 or V_TOTAL > 2048.
- Reset (asynchronous, while rst=1): hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, hsync=~SYNC_ACT, vsync=~SYNC_ACT.
- All outputs are registers, with no combinational path from input to output.
  - Every flag is computed from the next counter values, so flags and counters describe the same pixel in the same cycle.
- Counter sequence, on a clock edge with en=1:
  - hcount==H_TOTAL-1: hcount wraps to 0.
  - Otherwise hcount increments by 1.
  - vcount increments only when hcount wraps.
  - vcount==V_TOTAL-1 at an hcount wrap: vcount wraps to 0.
- en=0: counters and all flags hold; frame_start is forced to 0 (pulse not repeated).
- Flag decode, applied to the registered counter values:
  - hblnk = (hcount >= H_ACTIVE)
  - hsync = SYNC_ACT when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; ~SYNC_ACT otherwise
  - vblnk = (vcount >= V_ACTIVE)
  - vsync = SYNC_ACT when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; ~SYNC_ACT otherwise
  - vsync is line-based; it changes only on hcount wrap edges.
- frame_start:
  - Registered; high exactly on the cycle where the outputs show (0,0), after an enabled advance.
  - Low in the first cycle after reset release, because no advance has occurred yet.
- First-cycle behaviour: the first enabled edge after reset shows hcount=1, so the (0,0) pixel is visible for exactly one cycle out of reset.
- Reset mid-frame: counters return to 0 asynchronously, with no glitch pulse on frame_start.
  - Downstream draw stages tolerate this as a frame abort.
- No internal state beyond the two counters, the flag registers and the frame_start register.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (16 bits).
  - Reset value 0.
  - Increments by 1 on each cycle where frame_start is asserted; wraps 65535 -> 0.
  - Used for blink and animation timing in the end-game screens.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then en=1 for 1344 cycles -> hcount steps 0..1343, wraps to 0, vcount becomes 1; hblnk rises at hcount=1024 and falls at hcount=0.
- Default parameters, run one line -> hsync==SYNC_ACT exactly for hcount 1048..1183 (136 cycles); hblnk high for 320 cycles.
- Run a full frame (1344*806 = 1083264 cycles):
  - vsync asserted for vcount 771..776;
  - vblnk for vcount 768..805;
  - frame_start pulses once per frame, spaced exactly 1083264 cycles apart.
- Toggle en low for 10 cycles at hcount=500, vcount=300 -> all outputs frozen for those 10 cycles, no frame_start; the sequence resumes at 501.
- Assert rst asynchronously (between clock edges) at hcount=700, vcount=400 -> outputs go to reset values immediately; after release the counts restart from 0 and frame_start first pulses one full frame later.
- With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 1, 2, 3 at successive frame_start pulses; a forced counter of 65535 wraps to 0.
